iq_noise_source: RTL and testbench
==================================

// Module: iq_noise_source
//
// PURPOSE
// Deterministic pseudo-random IQ noise generator feeding 12-bit re/im samples
// into the receive chain input (re_in/im_in) for self-test and spectrometer
// noise-floor measurements. Two independent xorshift32 generators; each sample
// is the sum of four signed bytes (approximately Gaussian), then gain-shifted and saturated.
//
// PARAMETERS
// WIDTH    12            output sample width per component (two's complement)
// SEED_RE  32'h00000001  re generator state after reset (must be nonzero)
// SEED_IM  32'h2545F491  im generator state after reset (must be nonzero)
//
// PORTS
// clk           in   1      single clock; all logic on rising edge
// rst_n         in   1      asynchronous, active-low reset
// enable        in   1      1 = strobes accepted; 0 = strobes ignored
// sample_strobe in   1      request one new sample (at most 1 per cycle)
// shift         in   3      gain: sum <<< shift (0..7), captured with strobe
// seed_load     in   1      pulse: reload both generators from seed
// seed          in   32     seed value for seed_load
// re_out        out  WIDTH  real sample, valid with valid_out
// im_out        out  WIDTH  imaginary sample, valid with valid_out
// valid_out     out  1      one-cycle pulse per produced sample
// sample_count  out  32     number of samples produced since reset, wraps
//
// BEHAVIOUR
// - Reset: state_re=SEED_RE, state_im=SEED_IM; re_out=im_out=0, valid_out=0,
//   sample_count=0, all pipeline valids 0. Asynchronous assert, sync release.
// - Accept: strobe accepted at edge k iff sample_strobe & enable & ~seed_load.
// - Stage 0 (edge k): each state x <= xs(x), xs: x^=x<<13; x^=x>>17; x^=x<<5
//   (32-bit, bits shifted out discarded); shift captured into s0_shift.
// - Stage 1 (edge k+1): sum = sext(b0)+sext(b1)+sext(b2)+sext(b3) of new
//   state bytes, 10-bit signed, range [-512,508]; shift passed along.
// - Stage 2 (edge k+2): v = sum <<< shift in 17 bits; saturate to
//   [-2^(WIDTH-1), 2^(WIDTH-1)-1]; register to re_out/im_out; valid_out=1
//   for exactly the cycle after edge k+2; sample_count += 1 (wraps 2^32-1 -> 0).
// - Latency 2 cycles strobe->valid_out; throughput 1 sample/cycle; strobes
//   on consecutive cycles yield consecutive valid_out pulses, no drops.
// - Outputs hold last value when valid_out=0.
// - seed_load at edge: state_re<=seed, state_im<=seed^32'h9E3779B9; any zero
//   result replaced by the corresponding SEED_* parameter. Same-cycle strobe
//   is dropped (seed_load wins). Samples already in stages 1-2 still complete.
// - enable=0: new strobes ignored; in-flight samples drain normally.
// - Mid-operation reset discards in-flight samples; no valid_out after reset
//   until a new accepted strobe.
//
// TESTING
// 1. Reset, enable=1, shift=0, one strobe -> 2 cycles later valid_out=1,
//    re_out=69 (state 0x00042021), sample_count=1.
// 2. 1000 back-to-back strobes, shift=2 -> 1000 valid_out pulses, re/im match
//    bit-exact Python xorshift model, sample_count=1000.
// 3. shift=7, random stream -> each |sum|>=16 outputs exactly 2047 or -2048;
//    never outside range.
// 4. seed_load seed=1 with strobe same cycle -> no valid from that strobe;
//    next strobe reproduces test 1 value 69; seed=32'h9E3779B9 -> state_im
//    falls back to SEED_IM.
// 5. enable=0 with strobes -> no valid_out, outputs and count held; strobe
//    then enable drop -> in-flight sample still emitted.
// 6. rst_n low between strobe and valid -> valid_out stays 0, outputs 0,
//    count 0; sequence restarts from SEED_RE/SEED_IM.

Source files
------------

// File: rtl/iq_noise_source.sv
// iq_noise_source: two independent xorshift32 generators produce a pseudo-random
// complex noise stream. Each component is the sum of the four signed bytes of
// its generator state (roughly Gaussian), scaled by a left shift and saturated
// to WIDTH bits. Pipeline: state step -> byte sum -> gain/saturate, so valid_out
// pulses two cycles after an accepted strobe, at up to one sample per cycle.
module iq_noise_source #(
  parameter int          WIDTH   = 12,
  parameter logic [31:0] SEED_RE = 32'h0000_0001,
  parameter logic [31:0] SEED_IM = 32'h2545_F491
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sample_strobe,
  input  logic [2:0]       shift,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  output logic [WIDTH-1:0] re_out,
  output logic [WIDTH-1:0] im_out,
  output logic             valid_out,
  output logic [31:0]      sample_count
);

  // Mixing constant so the im generator diverges from re after a reseed.
  localparam logic [31:0] SEED_MIX = 32'h9E37_79B9;

  // Saturation limits expressed in the 17-bit gain domain
  // (10-bit sum shifted left by at most 7).
  localparam logic signed [16:0] SAT_MAX = 17'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [16:0] SAT_MIN = 17'(-(2 ** (WIDTH - 1)));

  // One xorshift32 step; bits shifted out of the 32-bit word are discarded.
  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Sum of the four bytes taken as signed values; range [-512, 508].
  function automatic logic signed [9:0] byte_sum(input logic [31:0] x);
    logic signed [9:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + $signed({{2{x[8*i+7]}}, x[8*i +: 8]});
    end
    return acc;
  endfunction

  // Arithmetic left shift in 17 bits, then clamp to the WIDTH-bit signed range.
  function automatic logic [WIDTH-1:0] gain_sat(input logic signed [9:0] s,
                                                input logic [2:0]        sh);
    logic signed [16:0] v;
    v = $signed({{7{s[9]}}, s}) <<< sh;
    if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return v[WIDTH-1:0];
  endfunction

  logic [31:0]       state_re_q, state_re_d;
  logic [31:0]       state_im_q, state_im_d;
  logic              s0_valid_q, s0_valid_d;
  logic [2:0]        s0_shift_q, s0_shift_d;
  logic              s1_valid_q, s1_valid_d;
  logic [2:0]        s1_shift_q, s1_shift_d;
  logic signed [9:0] s1_sum_re_q, s1_sum_re_d;
  logic signed [9:0] s1_sum_im_q, s1_sum_im_d;
  logic [WIDTH-1:0]  re_out_q, re_out_d;
  logic [WIDTH-1:0]  im_out_q, im_out_d;
  logic              valid_q, valid_d;
  logic [31:0]       count_q, count_d;

  logic              accept;
  logic [31:0]       mix_im;

  // Next-state logic for generators and all three pipeline stages.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned
    // (which would infer a latch); blocking '=' is correct in combinational code.
    state_re_d  = state_re_q;
    state_im_d  = state_im_q;
    s0_valid_d  = 1'b0;
    s0_shift_d  = s0_shift_q;
    s1_valid_d  = s0_valid_q;
    s1_shift_d  = s1_shift_q;
    s1_sum_re_d = s1_sum_re_q;
    s1_sum_im_d = s1_sum_im_q;
    re_out_d    = re_out_q;
    im_out_d    = im_out_q;
    valid_d     = s1_valid_q;
    count_d     = count_q;

    // A reseed takes priority: a strobe in the same cycle is dropped.
    accept = sample_strobe & enable & ~seed_load;
    mix_im = seed ^ SEED_MIX;

    // Stage 0: reseed, or advance both generators and capture the gain.
    if (seed_load) begin
      state_re_d = (seed   == 32'd0) ? SEED_RE : seed;
      state_im_d = (mix_im == 32'd0) ? SEED_IM : mix_im;
    end else if (accept) begin
      state_re_d = xs_step(state_re_q);
      state_im_d = xs_step(state_im_q);
      s0_valid_d = 1'b1;
      s0_shift_d = shift;
    end

    // Stage 1: byte sums of the states written by the previous stage-0 step.
    // A reseed landing on this same edge does not disturb them.
    if (s0_valid_q) begin
      s1_sum_re_d = byte_sum(state_re_q);
      s1_sum_im_d = byte_sum(state_im_q);
      s1_shift_d  = s0_shift_q;
    end

    // Stage 2: gain, saturate and publish; outputs hold between samples.
    if (s1_valid_q) begin
      re_out_d = gain_sat(s1_sum_re_q, s1_shift_q);
      im_out_d = gain_sat(s1_sum_im_q, s1_shift_q);
      count_d  = count_q + 32'd1;
    end
  end

  // State register for generators, pipeline and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values; the pipeline is small, so its data is reset as well.
    if (!rst_n) begin
      state_re_q  <= SEED_RE;
      state_im_q  <= SEED_IM;
      s0_valid_q  <= 1'b0;
      s0_shift_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_shift_q  <= '0;
      s1_sum_re_q <= '0;
      s1_sum_im_q <= '0;
      re_out_q    <= '0;
      im_out_q    <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_re_q  <= state_re_d;
      state_im_q  <= state_im_d;
      s0_valid_q  <= s0_valid_d;
      s0_shift_q  <= s0_shift_d;
      s1_valid_q  <= s1_valid_d;
      s1_shift_q  <= s1_shift_d;
      s1_sum_re_q <= s1_sum_re_d;
      s1_sum_im_q <= s1_sum_im_d;
      re_out_q    <= re_out_d;
      im_out_q    <= im_out_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
    end
  end

  assign re_out       = re_out_q;
  assign im_out       = im_out_q;
  assign valid_out    = valid_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_iq_noise_source.sv
// Testbench for iq_noise_source: constant-vector table for the basic sequence,
// hand-written corner sequences, and randomized traffic, all checked every
// cycle against a scoreboard fed by an arithmetic reference model.
module tb_iq_noise_source;

  localparam int          WIDTH   = 12;
  localparam logic [31:0] SEED_RE = 32'h0000_0001;
  localparam logic [31:0] SEED_IM = 32'h2545_F491;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             sample_strobe;
  logic [2:0]       shift;
  logic             seed_load;
  logic [31:0]      seed;
  logic [WIDTH-1:0] re_out;
  logic [WIDTH-1:0] im_out;
  logic             valid_out;
  logic [31:0]      sample_count;

  iq_noise_source #(
    .WIDTH  (WIDTH),
    .SEED_RE(SEED_RE),
    .SEED_IM(SEED_IM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_strobe(sample_strobe),
    .shift        (shift),
    .seed_load    (seed_load),
    .seed         (seed),
    .re_out       (re_out),
    .im_out       (im_out),
    .valid_out    (valid_out),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int               due;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } exp_t;

  exp_t             sb[$];
  logic [31:0]      m_re, m_im;
  logic [WIDTH-1:0] m_last_re, m_last_im;
  logic [31:0]      m_count;
  int               cycle;
  int               valid_pulses;

  function automatic logic [31:0] xorshift(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Sum of signed bytes times 2^shift, clamped to the output range.
  function automatic logic [WIDTH-1:0] model_sample(input logic [31:0] x, input int sh);
    int s;
    int b;
    int v;
    logic [WIDTH-1:0] r;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      b = int'((x >> (8 * i)) & 32'hFF);
      if (b >= 128) b -= 256;
      s += b;
    end
    v = s * (1 << sh);
    if (v > 2047)  v = 2047;
    if (v < -2048) v = -2048;
    r = v[WIDTH-1:0];
    return r;
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_re      = SEED_RE;
    m_im      = SEED_IM;
    m_last_re = '0;
    m_last_im = '0;
    m_count   = '0;
  endfunction

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic cyc(input logic en, input logic stb, input logic [2:0] sh,
                     input logic ld, input logic [31:0] sd);
    exp_t e;
    logic exp_valid;
    enable        = en;
    sample_strobe = stb;
    shift         = sh;
    seed_load     = ld;
    seed          = sd;
    @(posedge clk);
    cycle++;
    if (ld) begin
      m_re = (sd == 0) ? SEED_RE : sd;
      m_im = ((sd ^ 32'h9E3779B9) == 0) ? SEED_IM : (sd ^ 32'h9E3779B9);
    end else if (en && stb) begin
      m_re  = xorshift(m_re);
      m_im  = xorshift(m_im);
      e.due = cycle + 2;
      e.re  = model_sample(m_re, int'(sh));
      e.im  = model_sample(m_im, int'(sh));
      sb.push_back(e);
    end
    exp_valid = 1'b0;
    if (sb.size() > 0 && sb[0].due == cycle) begin
      e         = sb.pop_front();
      exp_valid = 1'b1;
      m_last_re = e.re;
      m_last_im = e.im;
      m_count   = m_count + 1;
    end
    #1;
    if (valid_out === 1'b1) valid_pulses++;
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    check("re_out", 32'(re_out), 32'(m_last_re));
    check("im_out", 32'(im_out), 32'(m_last_im));
    check("sample_count", sample_count, m_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    enable        = 1'b0;
    sample_strobe = 1'b0;
    shift         = 3'd0;
    seed_load     = 1'b0;
    seed          = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             en;
    logic             stb;
    logic [2:0]       sh;
    logic             ld;
    logic [31:0]      sd;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_re;
    logic [31:0]      exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic stb, input logic [2:0] sh,
                              input logic ld, input logic [31:0] sd,
                              input logic ev, input logic [WIDTH-1:0] er,
                              input logic [31:0] ec);
    vec_t v;
    v.en = en; v.stb = stb; v.sh = sh; v.ld = ld; v.sd = sd;
    v.exp_valid = ev; v.exp_re = er; v.exp_cnt = ec;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    // xorshift(1) = 0x00042021 -> bytes 0x21+0x20+0x04+0x00 = 69.
    vecs[0]  = mk(1, 1, 0, 0, 32'd0, 0, 12'd0,    0); // strobe, shift 0
    vecs[1]  = mk(1, 0, 0, 0, 32'd0, 0, 12'd0,    0);
    vecs[2]  = mk(1, 0, 0, 0, 32'd0, 1, 12'd69,   1); // two cycles later
    vecs[3]  = mk(1, 0, 0, 0, 32'd0, 0, 12'd69,   1); // hold
    vecs[4]  = mk(1, 1, 0, 1, 32'd1, 0, 12'd69,   1); // reseed wins over strobe
    vecs[5]  = mk(1, 0, 0, 0, 32'd0, 0, 12'd69,   1);
    vecs[6]  = mk(1, 0, 0, 0, 32'd0, 0, 12'd69,   1);
    vecs[7]  = mk(1, 1, 0, 0, 32'd0, 0, 12'd69,   1);
    vecs[8]  = mk(1, 0, 0, 0, 32'd0, 0, 12'd69,   1);
    vecs[9]  = mk(1, 0, 0, 0, 32'd0, 1, 12'd69,   2); // seed 1 reproduces 69
    vecs[10] = mk(1, 0, 0, 1, 32'd0, 0, 12'd69,   2); // seed 0 -> SEED_RE
    vecs[11] = mk(1, 1, 1, 0, 32'd0, 0, 12'd69,   2);
    vecs[12] = mk(1, 0, 0, 0, 32'd0, 0, 12'd69,   2);
    vecs[13] = mk(1, 0, 0, 0, 32'd0, 1, 12'd138,  3); // 69 << 1
    vecs[14] = mk(1, 0, 0, 1, 32'd0, 0, 12'd138,  3);
    vecs[15] = mk(1, 1, 7, 0, 32'd0, 0, 12'd138,  3); // 69 << 7 saturates
    vecs[16] = mk(1, 0, 0, 0, 32'd0, 0, 12'd138,  3);
    vecs[17] = mk(1, 0, 0, 0, 32'd0, 1, 12'h7FF,  4);
    vecs[18] = mk(0, 1, 0, 0, 32'd0, 0, 12'h7FF,  4); // disabled strobe ignored
    vecs[19] = mk(1, 0, 0, 0, 32'd0, 0, 12'h7FF,  4);
    vecs[20] = mk(1, 0, 0, 0, 32'd0, 0, 12'h7FF,  4);
  end

  // ---------------- test sequence ----------------
  initial begin
    cycle        = 0;
    valid_pulses = 0;
    do_reset();
    #1;
    check("reset valid_out", 32'(valid_out), 32'd0);
    check("reset re_out", 32'(re_out), 32'd0);
    check("reset im_out", 32'(im_out), 32'd0);
    check("reset sample_count", sample_count, 32'd0);

    // Directed table.
    for (int i = 0; i < 21; i++) begin
      cyc(vecs[i].en, vecs[i].stb, vecs[i].sh, vecs[i].ld, vecs[i].sd);
      check($sformatf("vec%0d valid", i), 32'(valid_out), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d re", i), 32'(re_out), 32'(vecs[i].exp_re));
      check($sformatf("vec%0d count", i), sample_count, vecs[i].exp_cnt);
    end

    // Reseed whose im mix is zero: im falls back to SEED_IM.
    cyc(1, 0, 0, 1, 32'h9E3779B9);
    cyc(1, 1, 0, 0, 32'd0);
    idle(2);
    check("mix-zero im", 32'(im_out), 32'(model_sample(xorshift(SEED_IM), 0)));

    // Enable drop with a sample in flight: it still drains.
    cyc(1, 1, 3, 0, 32'd0);
    cyc(0, 1, 3, 0, 32'd0);
    cyc(0, 1, 3, 0, 32'd0);
    cyc(0, 0, 3, 0, 32'd0);

    // Back-to-back burst of 1000 strobes with shift 2.
    do_reset();
    valid_pulses = 0;
    for (int i = 0; i < 1000; i++) cyc(1, 1, 2, 0, 32'd0);
    idle(3);
    check("burst pulses", 32'(valid_pulses), 32'd1000);
    check("burst count", sample_count, 32'd1000);

    // Shift 7 random stream: heavy saturation.
    for (int i = 0; i < 300; i++) cyc(1, 1'($urandom_range(0, 1)), 3'd7, 0, 32'd0);
    idle(3);

    // Reset between strobe and valid: in-flight sample discarded.
    cyc(1, 1, 0, 0, 32'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset valid_out", 32'(valid_out), 32'd0);
    check("midreset re_out", 32'(re_out), 32'd0);
    check("midreset count", sample_count, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    cyc(1, 1, 0, 0, 32'd0);
    idle(2);
    check("restart re", 32'(re_out), 32'd69);

    // Randomized traffic with occasional reseeds.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 40) == 0),
          ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom()));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
